axi_txn_sequencer: RTL and testbench
====================================

// Module: axi_txn_sequencer
// PURPOSE
//  Synthesizable instruction sequencer for the AXI4-Lite master (c_m00_* user ports).
//  Issues N back-to-back LOAD_DATA/WRITE_DATA instructions over strided off-memory address ranges.
//  Owns the txn_en / inst_done handshake so the control unit issues a single start per block move.
//  Sits between the control unit and the AXI4-Lite master.
// PARAMETERS
//  ADDR_WIDTH     32    width of off-memory addresses A/B
//  CNT_WIDTH      16    width of instruction count and index
//  TIMEOUT_CYCLES 1024  max cycles to wait for one inst_done edge (only with AXI_SEQ_TIMEOUT_EN)
// PORTS
//  clk           in   1           clock
//  reset         in   1           async, active-high reset
//  start         in   1           1-cycle pulse; latches cfg_* when idle
//  abort         in   1           stop after the current instruction completes
//  cfg_mode      in   2           00 IDLE (illegal), 01 LOAD_DATA, 10 WRITE_DATA, 11 illegal
//  cfg_base_a    in   ADDR_WIDTH  first addra
//  cfg_base_b    in   ADDR_WIDTH  first addrb
//  cfg_stride_a  in   ADDR_WIDTH  addra increment per instruction
//  cfg_stride_b  in   ADDR_WIDTH  addrb increment per instruction
//  cfg_count     in   CNT_WIDTH   number of instructions
//  m_mode        out  2           to master c_m00_mode
//  m_addra       out  ADDR_WIDTH  to master c_m00_off_mem_addra
//  m_addrb       out  ADDR_WIDTH  to master c_m00_off_mem_addrb
//  m_txn_en      out  1           to master m00_axi_txn_en
//  m_inst_done   in   1           from master m00_axi_inst_done
//  busy          out  1           high from accepted start until done
//  done          out  1           1-cycle pulse at end of sequence
//  error         out  1           sticky until next accepted start: illegal mode or timeout
//  issued        out  CNT_WIDTH   instructions completed in the current sequence
// BEHAVIOUR
//  - Reset (async, active-high): every output = 0; state = S_IDLE; internal regs cleared.
//  - Reset mid-sequence: m_txn_en drops immediately; the sequence is lost and is not resumed.
//  - FSM states:
//    - S_IDLE:
//      - start & cfg_mode in {01,10} & cfg_count!=0: latch cfg_*, issued=0, error=0, busy=1 -> S_ARM.
//      - start & cfg_count==0 (legal mode): done=1 next cycle, busy stays 0.
//      - start & illegal mode: error=1, done=1, busy stays 0.
//    - S_ARM: wait for m_inst_done==0. Then drive m_mode, m_addra, m_addrb; m_txn_en=1 -> S_ISSUE.
//    - S_ISSUE: hold m_txn_en, mode and addresses stable until m_inst_done==1.
//      Then m_txn_en=0, issued+1, addra+=stride_a, addrb+=stride_b -> S_NEXT.
//    - S_NEXT:
//      - issued==count or abort_pend: busy=0, done=1 -> S_IDLE.
//      - otherwise -> S_ARM.
//  - Addresses wrap modulo 2^ADDR_WIDTH. No saturation, no error on wrap.
//  - m_addra/m_addrb/m_mode change only in S_ARM->S_ISSUE; held after txn_en falls.
//  - Latency:
//    - start -> first m_txn_en: 2 cycles if m_inst_done is already 0.
//    - inst_done rise -> next m_txn_en: 3 cycles.
//  - abort: sets abort_pend in any busy state; it never cuts an in-flight instruction.
//    Ignored in S_IDLE.
//  - start while busy is ignored. start and abort in the same cycle from S_IDLE: start wins.
//  - cfg_* are sampled only on an accepted start; later changes have no effect.
// CONFIGURATION
//  AXI_SEQ_TIMEOUT_EN defined:
//    - Cycle counter runs in S_ARM and S_ISSUE; it resets on each state entry.
//    - Reaching TIMEOUT_CYCLES: m_txn_en=0, error=1, done=1, busy=0 -> S_IDLE.
//  AXI_SEQ_TIMEOUT_EN undefined: no counter; waits indefinitely. error is set only by illegal mode.
// TESTING
//  1 LOAD, base_b=0, stride_b=4, count=64, slave model answers in 5 cycles:
//    -> 64 txn_en pulses, addrb 0,4,...,252; issued=64; one done pulse.
//  2 WRITE, base_a=0x100, stride_a=0x10, count=3:
//    -> addra 0x100,0x110,0x120; m_mode=10 on every pulse.
//  3 count=0 -> done pulse with no txn_en. mode=11 -> error=1, done=1, no txn_en.
//  4 abort asserted during 2nd of 8 instructions
//    -> 2nd completes, done after issued=2, no 3rd txn_en.
//  5 base_b=0xFFFFFFF8, stride_b=4, count=4 -> addrb FFFFFFF8, FFFFFFFC, 0, 4.
//  6 reset mid-ISSUE -> all outputs 0 within the same cycle.
//    With AXI_SEQ_TIMEOUT_EN and slave never asserting done: error=1 after 1024 cycles.

Source files
------------

// File: rtl/axi_txn_sequencer_if.sv
// Bus between the transaction sequencer and the AXI4-Lite master's user ports.
// The master modport is the sequencer side and the slave modport is the AXI master side.
interface axi_txn_sequencer_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic [1:0]            m_mode;
  logic [ADDR_WIDTH-1:0] m_addra;
  logic [ADDR_WIDTH-1:0] m_addrb;
  logic                  m_txn_en;
  logic                  m_inst_done;

  modport master (
    output m_mode,
    output m_addra,
    output m_addrb,
    output m_txn_en,
    input  m_inst_done
  );

  modport slave (
    input  m_mode,
    input  m_addra,
    input  m_addrb,
    input  m_txn_en,
    output m_inst_done
  );
endinterface

// File: rtl/axi_txn_sequencer.sv
// Issues cfg_count strided LOAD_DATA/WRITE_DATA instructions to the AXI4-Lite master from a single start.
// Defining AXI_SEQ_TIMEOUT_EN adds a per-state watchdog of TIMEOUT_CYCLES cycles.
module axi_txn_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            cfg_mode,
  input  logic [ADDR_WIDTH-1:0] cfg_base_a,
  input  logic [ADDR_WIDTH-1:0] cfg_base_b,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_a,
  input  logic [ADDR_WIDTH-1:0] cfg_stride_b,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  axi_txn_sequencer_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  issued
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ISSUE, S_NEXT} state_t;

  state_t                state, state_d;
  logic [1:0]            mode_r, m_mode_r;
  logic [ADDR_WIDTH-1:0] addra_nx, addrb_nx, stride_a_r, stride_b_r;
  logic [ADDR_WIDTH-1:0] m_addra_r, m_addrb_r;
  logic [CNT_WIDTH-1:0]  count_r;
  logic                  abort_pend, txn_en_r;
  logic                  cfg_legal, accept, arm_go, issue_end, finish, tmo_fire, timeout;

  assign cfg_legal = (cfg_mode == 2'b01) || (cfg_mode == 2'b10);

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    arm_go    = 1'b0;
    issue_end = 1'b0;
    finish    = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && cfg_legal && (cfg_count != '0)) begin
          accept  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        // The master must have released inst_done from the previous instruction first.
        if (!bus.m_inst_done) begin
          arm_go  = 1'b1;
          state_d = S_ISSUE;
        end else if (timeout) begin
          tmo_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (bus.m_inst_done) begin
          issue_end = 1'b1;
          state_d   = S_NEXT;
        end else if (timeout) begin
          tmo_fire = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_NEXT: begin
        if ((issued == count_r) || abort_pend || abort) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AXI_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Restarts on every state entry so each wait phase gets the full budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state_d != state) || ((state != S_ARM) && (state != S_ISSUE))) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign timeout = ((state == S_ARM) || (state == S_ISSUE)) &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_r     <= '0;
      addra_nx   <= '0;
      addrb_nx   <= '0;
      stride_a_r <= '0;
      stride_b_r <= '0;
      count_r    <= '0;
      abort_pend <= 1'b0;
      m_mode_r   <= '0;
      m_addra_r  <= '0;
      m_addrb_r  <= '0;
      txn_en_r   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      issued     <= '0;
    end else begin
      state <= state_d;
      done  <= ((state == S_IDLE) && start && !accept) || finish || tmo_fire;

      if ((state == S_IDLE) && start) begin
        issued <= '0;
        error  <= !cfg_legal;
      end

      if (accept) begin
        mode_r     <= cfg_mode;
        addra_nx   <= cfg_base_a;
        addrb_nx   <= cfg_base_b;
        stride_a_r <= cfg_stride_a;
        stride_b_r <= cfg_stride_b;
        count_r    <= cfg_count;
        abort_pend <= 1'b0;
        busy       <= 1'b1;
      end else if (busy && abort) begin
        abort_pend <= 1'b1;
      end

      // Bus outputs only move here, so they stay put after txn_en falls.
      if (arm_go) begin
        m_mode_r  <= mode_r;
        m_addra_r <= addra_nx;
        m_addrb_r <= addrb_nx;
        txn_en_r  <= 1'b1;
      end

      if (issue_end) begin
        txn_en_r <= 1'b0;
        issued   <= issued + 1'b1;
        addra_nx <= addra_nx + stride_a_r;
        addrb_nx <= addrb_nx + stride_b_r;
      end

      if (finish) begin
        busy <= 1'b0;
      end

      if (tmo_fire) begin
        txn_en_r <= 1'b0;
        error    <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

  assign bus.m_mode   = m_mode_r;
  assign bus.m_addra  = m_addra_r;
  assign bus.m_addrb  = m_addrb_r;
  assign bus.m_txn_en = txn_en_r;

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Scoreboard bench for axi_txn_sequencer: directed scenarios plus randomized sequences against a
// queue-based reference model, with an AXI master stand-in answering txn_en after a programmable delay.
module tb_axi_txn_sequencer;

  localparam int AW = 32;
  localparam int CW = 16;

  typedef struct {
    logic [1:0]    mode;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } txn_t;

  typedef struct {
    logic [CW-1:0] issued;
    logic          err;
  } dn_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [AW-1:0] cfg_base_a = '0;
  logic [AW-1:0] cfg_base_b = '0;
  logic [AW-1:0] cfg_stride_a = '0;
  logic [AW-1:0] cfg_stride_b = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          busy, done, error;
  logic [CW-1:0] issued;

  axi_txn_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  axi_txn_sequencer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(1024)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg_mode     (cfg_mode),
    .cfg_base_a   (cfg_base_a),
    .cfg_base_b   (cfg_base_b),
    .cfg_stride_a (cfg_stride_a),
    .cfg_stride_b (cfg_stride_b),
    .cfg_count    (cfg_count),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .issued       (issued)
  );

  always #5 clk = ~clk;

  txn_t exp_txn[$];
  dn_t  exp_dn[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   slave_lat = 3;
  int   slave_drop = 0;
  bit   slave_stall = 1'b0;
  bit   lat_chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_txn_en"}, bus.m_txn_en, 0);
    check({tag, "_mode"},   bus.m_mode, 0);
    check({tag, "_addra"},  bus.m_addra, 0);
    check({tag, "_addrb"},  bus.m_addrb, 0);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_error"},  error, 0);
    check({tag, "_issued"}, issued, 0);
  endtask

  task automatic scramble_cfg();
    cfg_mode     = 2'($urandom_range(0, 3));
    cfg_base_a   = $urandom;
    cfg_base_b   = $urandom;
    cfg_stride_a = $urandom;
    cfg_stride_b = $urandom;
    cfg_count    = 16'($urandom_range(0, 20));
  endtask

  // Reference model: instruction i goes to base + i*stride (mod 2^32); abort cuts after instruction k.
  task automatic run_seq(input logic [1:0] mode, input logic [AW-1:0] ba, input logic [AW-1:0] bb,
                         input logic [AW-1:0] sa, input logic [AW-1:0] sb, input int cnt,
                         input int abort_at, input bit chk_lat, input bit poke, input bit start_abort);
    int   n, cyc, rises;
    bit   legal, prev, aborted, seen;
    txn_t t;
    dn_t  d;
    legal = (mode == 2'b01) || (mode == 2'b10);
    n = !legal ? 0 : ((abort_at > 0 && abort_at < cnt) ? abort_at : cnt);
    for (int i = 0; i < n; i++) begin
      t.mode = mode;
      t.a    = ba + sa * 32'(i);
      t.b    = bb + sb * 32'(i);
      exp_txn.push_back(t);
    end
    d.issued = 16'(n);
    d.err    = !legal;
    exp_dn.push_back(d);

    cfg_mode = mode; cfg_base_a = ba; cfg_base_b = bb;
    cfg_stride_a = sa; cfg_stride_b = sb; cfg_count = 16'(cnt);
    start = 1'b1;
    abort = start_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    scramble_cfg();
    cyc = 1; rises = 0; prev = 1'b0; aborted = 1'b0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      if (bus.m_txn_en && !prev) begin
        rises++;
        if (rises == 1 && chk_lat) check("start_to_txn_lat", 64'(cyc), 2);
      end
      prev = bus.m_txn_en;
      if (done) begin
        seen = 1'b1;
      end else begin
        abort = (abort_at > 0) && (rises == abort_at) && bus.m_txn_en && !aborted;
        if (abort) aborted = 1'b1;
        start = poke && (cyc == 5) && busy;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check("seq_done_seen", seen, 1);
    repeat (3) @(negedge clk);
  endtask

  // AXI master stand-in: raises inst_done slave_lat cycles into a transaction, drops it after txn_en falls.
  initial begin : slave
    int wcnt, dcnt;
    wcnt = 0;
    dcnt = 0;
    bus.m_inst_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        bus.m_inst_done = 1'b0;
        wcnt = 0;
        dcnt = 0;
      end else if (!bus.m_inst_done) begin
        if (bus.m_txn_en && !slave_stall) begin
          wcnt++;
          if (wcnt >= slave_lat) begin
            bus.m_inst_done = 1'b1;
            wcnt = 0;
          end
        end
      end else if (!bus.m_txn_en) begin
        if (dcnt >= slave_drop) begin
          bus.m_inst_done = 1'b0;
          dcnt = 0;
        end else begin
          dcnt++;
        end
      end
    end
  end

  initial begin : monitor
    txn_t cur;
    dn_t  d;
    bit   prev_en, prev_dn, prev_idone;
    int   gap;
    prev_en = 1'b0; prev_dn = 1'b0; prev_idone = 1'b0; gap = -1;
    cur.mode = '0; cur.a = '0; cur.b = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_en = 1'b0; prev_dn = 1'b0; prev_idone = 1'b0; gap = -1;
      end else begin
        if (bus.m_inst_done && !prev_idone) gap = 0;
        else if (gap >= 0) gap++;
        if (bus.m_txn_en && !prev_en) begin
          if (lat_chk_en && gap >= 0) check("done_to_txn_lat", 64'(gap), 3);
          gap = -1;
          check("txn_expected", exp_txn.size() != 0, 1);
          if (exp_txn.size() != 0) begin
            cur = exp_txn.pop_front();
            check("txn_mode",  bus.m_mode,  cur.mode);
            check("txn_addra", bus.m_addra, cur.a);
            check("txn_addrb", bus.m_addrb, cur.b);
          end
        end else if (bus.m_txn_en) begin
          check("hold_mode",  bus.m_mode,  cur.mode);
          check("hold_addra", bus.m_addra, cur.a);
          check("hold_addrb", bus.m_addrb, cur.b);
        end
        if (done) begin
          gap = -1;
          check("done_single_cycle", prev_dn, 0);
          check("done_expected", exp_dn.size() != 0, 1);
          if (exp_dn.size() != 0) begin
            d = exp_dn.pop_front();
            check("done_issued", issued, d.issued);
            check("done_error",  error,  d.err);
            check("done_busy",   busy,   0);
            check("done_txn_en", bus.m_txn_en, 0);
          end
        end
        prev_en    = bus.m_txn_en;
        prev_dn    = done;
        prev_idone = bus.m_inst_done;
      end
    end
  end

  initial begin : driver
    int   cnt, ab, rises, cyc;
    bit   prev, seen;
    txn_t t;
    dn_t  d;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // LOAD x64, 5-cycle answers, immediate inst_done release
    slave_lat = 5; slave_drop = 0; lat_chk_en = 1'b1;
    run_seq(2'b01, $urandom, 32'h0, $urandom, 32'h4, 64, 0, 1'b1, 1'b0, 1'b0);
    lat_chk_en = 1'b0;

    // WRITE x3, start and abort together from idle
    slave_lat = 2; slave_drop = 1;
    run_seq(2'b10, 32'h100, $urandom, 32'h10, $urandom, 3, 0, 1'b1, 1'b1, 1'b1);

    run_seq(2'b01, $urandom, $urandom, $urandom, $urandom, 0, 0, 1'b0, 1'b0, 1'b0);
    run_seq(2'b11, $urandom, $urandom, $urandom, $urandom, 5, 0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("error_sticky", error, 1);
    run_seq(2'b00, $urandom, $urandom, $urandom, $urandom, 2, 0, 1'b0, 1'b0, 1'b0);

    // abort during the 2nd of 8
    slave_lat = 4; slave_drop = 0;
    run_seq(2'b01, $urandom, $urandom, $urandom, $urandom, 8, 2, 1'b1, 1'b0, 1'b0);

    // addrb wraps past 2^32
    slave_lat = 1;
    run_seq(2'b10, $urandom, 32'hFFFF_FFF8, $urandom, 32'h4, 4, 0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      slave_lat  = $urandom_range(1, 6);
      slave_drop = $urandom_range(0, 2);
      cnt = $urandom_range(1, 6);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, cnt) : 0;
      run_seq(2'($urandom_range(1, 2)), $urandom, $urandom, $urandom, $urandom, cnt, ab, 1'b1,
              1'($urandom_range(0, 1)), 1'b0);
    end

    // reset in the middle of the 2nd instruction of 8
    slave_lat = 6; slave_drop = 0;
    for (int i = 0; i < 2; i++) begin
      t.mode = 2'b01; t.a = 32'h1000 + 32'h20 * 32'(i); t.b = 32'h8000 + 32'h8 * 32'(i);
      exp_txn.push_back(t);
    end
    cfg_mode = 2'b01; cfg_base_a = 32'h1000; cfg_base_b = 32'h8000;
    cfg_stride_a = 32'h20; cfg_stride_b = 32'h8; cfg_count = 16'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; prev = 1'b0;
    for (int c = 0; c < 200 && rises < 2; c++) begin
      if (bus.m_txn_en && !prev) rises++;
      prev = bus.m_txn_en;
      if (rises < 2) @(negedge clk);
    end
    check("reset_test_reached_2nd", 64'(rises), 2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("no_resume_busy", busy, 0);
    slave_lat = 2;
    run_seq(2'b10, $urandom, $urandom, $urandom, $urandom, 3, 0, 1'b1, 1'b0, 1'b0);

`ifdef AXI_SEQ_TIMEOUT_EN
    // the stand-in master never answers: watchdog must end the sequence
    slave_stall = 1'b1;
    t.mode = 2'b01; t.a = 32'h40; t.b = 32'h80;
    exp_txn.push_back(t);
    d.issued = 16'd0; d.err = 1'b1;
    exp_dn.push_back(d);
    cfg_mode = 2'b01; cfg_base_a = 32'h40; cfg_base_b = 32'h80;
    cfg_stride_a = 32'h4; cfg_stride_b = 32'h4; cfg_count = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("timeout_done_seen", seen, 1);
    check("timeout_cycle", 64'(cyc), 1026);
    slave_stall = 1'b0;
    repeat (3) @(negedge clk);
    check("timeout_error_sticky", error, 1);
`endif

    repeat (5) @(negedge clk);
    check("txn_queue_drained", 64'(exp_txn.size()), 0);
    check("done_queue_drained", 64'(exp_dn.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
